// File: rtl/mac_loader_pkg.sv
// mac_loader_pkg: shared state encoding, header bit positions and
// size helpers for the MAC operand loader (mac_operand_loader).
package mac_loader_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PAYLOAD = 3'd1;
  localparam logic [2:0] CHECK   = 3'd2;
  localparam logic [2:0] APPLY   = 3'd3;
  localparam logic [2:0] COMMIT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = IDLE,
    S_PAYLOAD = PAYLOAD,
    S_CHECK   = CHECK,
    S_APPLY   = APPLY,
    S_COMMIT  = COMMIT
  } state_t;

  localparam int HDR_TARGET = 0;
  localparam int HDR_COMMIT = 1;

  function automatic int nbytes(input int n_stage);
    return (1 << n_stage) / 8;
  endfunction

  // byte counter width, never below one bit
  function automatic int cnt_w(input int n_stage);
    return (n_stage > 4) ? n_stage - 3 : 1;
  endfunction

endpackage

// File: rtl/operand_byte_shreg.sv
// operand_byte_shreg: byte-indexed staging register with running XOR.
// Ports: start seeds xsum with din and clears data; wr_en writes byte idx; clr drops all.
module operand_byte_shreg #(
  parameter int NBYTES = 8,
  parameter int IDX_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  wr_en,
  input  logic                  clr,
  input  logic [IDX_W-1:0]      idx,
  input  logic [7:0]            din,
  output logic [8*NBYTES-1:0]   data,
  output logic [7:0]            xsum
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      data <= '0;
      xsum <= '0;
    end else if (start) begin
      data <= '0;
      xsum <= din;
    end else if (wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (idx == IDX_W'(i)) begin
          data[8*i +: 8] <= din;
        end
      end
      xsum <= xsum ^ din;
    end
  end

endmodule

// File: rtl/mac_operand_loader.sv
// mac_operand_loader: byte-serial loader committing w/x operand vectors atomically.
// Ports: in_data/in_valid/in_ready byte stream; w_out/x_out/out_valid to MAC; err checksum pulse.
// Macro OPERAND_LOADER_CHECKSUM_EN adds a per-frame XOR checksum byte and drives err.
module mac_operand_loader
  import mac_loader_pkg::*;
#(
  parameter  int N_STAGE = 6,
  localparam int VEC_W   = 2 ** N_STAGE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [VEC_W-1:0] w_out,
  output logic [VEC_W-1:0] x_out,
  output logic             out_valid,
  output logic             err
);

  localparam int NB = nbytes(N_STAGE);
  localparam int CW = cnt_w(N_STAGE);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  state_t           state;
  logic [CW-1:0]    byte_cnt;
  logic             hdr_target;
  logic             hdr_commit;
  logic [VEC_W-1:0] shadow_w;
  logic [VEC_W-1:0] shadow_x;
  logic [VEC_W-1:0] stage_data;
  logic [7:0]       xsum;
  logic             acc;
  logic             sh_start;
  logic             sh_wr;
  logic             sh_clr;
  logic             chk_ok;

  assign in_ready = (state == S_IDLE) ||
                    (state == S_PAYLOAD) ||
                    (state == S_CHECK);
  assign acc      = in_valid & in_ready;
  assign sh_start = acc & (state == S_IDLE);
  assign sh_wr    = acc & (state == S_PAYLOAD);
  assign chk_ok   = (in_data == xsum);

`ifdef OPERAND_LOADER_CHECKSUM_EN
  assign sh_clr = acc & (state == S_CHECK) & ~chk_ok;
`else
  assign sh_clr = 1'b0;
  logic unused_chk;
  assign unused_chk = chk_ok;
`endif

  operand_byte_shreg #(
    .NBYTES (NB),
    .IDX_W  (CW)
  ) u_shreg (
    .clk   (clk),
    .reset (reset),
    .start (sh_start),
    .wr_en (sh_wr),
    .clr   (sh_clr),
    .idx   (byte_cnt),
    .din   (in_data),
    .data  (stage_data),
    .xsum  (xsum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      hdr_target <= 1'b0;
      hdr_commit <= 1'b0;
      shadow_w   <= '0;
      shadow_x   <= '0;
      w_out      <= '0;
      x_out      <= '0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            hdr_target <= in_data[HDR_TARGET];
            hdr_commit <= in_data[HDR_COMMIT];
            byte_cnt   <= '0;
            state      <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (in_valid) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == LAST) begin
              byte_cnt <= '0;
`ifdef OPERAND_LOADER_CHECKSUM_EN
              state    <= S_CHECK;
`else
              state    <= S_APPLY;
`endif
            end
          end
        end
`ifdef OPERAND_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (in_valid) begin
            err   <= ~chk_ok;
            state <= chk_ok ? S_APPLY : S_IDLE;
          end
        end
`endif
        S_APPLY: begin
          if (hdr_target) shadow_x <= stage_data;
          else            shadow_w <= stage_data;
          state <= hdr_commit ? S_COMMIT : S_IDLE;
        end
        S_COMMIT: begin
          w_out     <= shadow_w;
          x_out     <= shadow_x;
          out_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_loader.sv
// tb_mac_operand_loader: scoreboard bench for mac_operand_loader.
// Main DUT at N_STAGE=6, second instance at N_STAGE=3.
module tb_mac_operand_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] w_out;
  logic [63:0] x_out;
  logic        out_valid;
  logic        err;

  logic [7:0]  in8_data;
  logic        in8_valid;
  logic        in8_ready;
  logic [7:0]  w8;
  logic [7:0]  x8;
  logic        out8_valid;
  logic        err8;

  int vectors     = 0;
  int miscompares = 0;
  int ov_cnt      = 0;
  int err_cnt     = 0;
  int exp_err     = 0;

  logic [127:0] sb[$];
  logic [127:0] e;
  logic [63:0]  mw, mx, ow, ox;

  always #5 clk = ~clk;

  mac_operand_loader #(.N_STAGE(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .w_out     (w_out),
    .x_out     (x_out),
    .out_valid (out_valid),
    .err       (err)
  );

  mac_operand_loader #(.N_STAGE(3)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in8_data),
    .in_valid  (in8_valid),
    .in_ready  (in8_ready),
    .w_out     (w8),
    .x_out     (x8),
    .out_valid (out8_valid),
    .err       (err8)
  );

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      ov_cnt++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_extra: w=%h x=%h, none expected",
                 w_out, x_out);
      end else begin
        e = sb.pop_front();
        if ({w_out, x_out} !== e) begin
          miscompares++;
          $display("FAIL sb_vec: w=%h x=%h want w=%h x=%h",
                   w_out, x_out, e[127:64], e[63:0]);
        end
      end
    end
    if (!reset && err) err_cnt++;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    in8_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mw = '0; mx = '0; ow = '0; ox = '0;
    sb.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL send_to: in_ready=%b want 1", in_ready);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d pending want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] hdr,
                            input logic [63:0] d,
                            input bit gap, input bit lat);
    logic [7:0] x;
    x = hdr;
    send_byte(hdr);
    for (int i = 0; i < 8; i++) begin
      if (gap && i > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL gap_rdy: %b want 1", in_ready);
        end
      end
      send_byte(d[8*i +: 8]);
      x ^= d[8*i +: 8];
    end
`ifdef OPERAND_LOADER_CHECKSUM_EN
    send_byte(x);
`endif
    if (hdr[0]) mx = d;
    else        mw = d;
    if (hdr[1]) begin
      ow = mw;
      ox = mx;
      sb.push_back({ow, ox});
    end
    if (lat) begin
      @(negedge clk);
      in_valid = 1'b0;
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL lat_k1: rdy=%b ov=%b want 0 0",
                 in_ready, out_valid);
      end
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL lat_k2: rdy=%b ov=%b want 0 0",
                 in_ready, out_valid);
      end
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL lat_k3: rdy=%b ov=%b want 1 1",
                 in_ready, out_valid);
      end
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL lat_pulse: ov=%b want 0", out_valid);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (w_out !== 64'h0 || x_out !== 64'h0) begin
      miscompares++;
      $display("FAIL rst_out: w=%h x=%h want 0 0", w_out, x_out);
    end
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ctl: rdy=%b ov=%b err=%b want 1 0 0",
               in_ready, out_valid, err);
    end
    vectors++;
    if (w8 !== 8'h0 || x8 !== 8'h0 || in8_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_n3: w=%h x=%h rdy=%b want 0 0 1",
               w8, x8, in8_ready);
    end
  endtask

  task automatic run_s1(input bit gap, input string tag);
    int c0;
    c0 = ov_cnt;
    send_frame(8'h00, 64'h0807060504030201, gap, 1'b0);
    idle(4);
    vectors++;
    if (ov_cnt != c0 || w_out !== 64'h0) begin
      miscompares++;
      $display("FAIL %s_wonly: ov=%0d w=%h want %0d 0",
               tag, ov_cnt - c0, w_out, 0);
    end
    send_frame(8'h03, {64{1'b1}}, gap, 1'b1);
    drain();
    vectors++;
    if (ov_cnt != c0 + 1) begin
      miscompares++;
      $display("FAIL %s_cnt: %0d pulses want 1", tag, ov_cnt - c0);
    end
    vectors++;
    if (w_out !== 64'h0807060504030201 || x_out !== {64{1'b1}}) begin
      miscompares++;
      $display("FAIL %s_out: w=%h x=%h want 0807060504030201 ff..",
               tag, w_out, x_out);
    end
  endtask

  task automatic test_basic();
    do_reset();
    run_s1(1'b0, "basic");
  endtask

  task automatic test_gap();
    do_reset();
    run_s1(1'b1, "gap");
  endtask

`ifdef OPERAND_LOADER_CHECKSUM_EN
  task automatic send_bad(input logic [7:0] hdr,
                          input logic [63:0] d,
                          input logic [7:0] chk);
    send_byte(hdr);
    for (int i = 0; i < 8; i++) send_byte(d[8*i +: 8]);
    send_byte(chk);
    exp_err++;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (err !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_err: err=%b rdy=%b want 1 1", err, in_ready);
    end
    idle(4);
  endtask
`endif

  task automatic test_checksum();
`ifdef OPERAND_LOADER_CHECKSUM_EN
    int c0;
    c0 = ov_cnt;
    send_frame(8'h02, {8{8'hAA}}, 1'b0, 1'b0);
    drain();
    vectors++;
    if (ov_cnt != c0 + 1 || w_out !== {8{8'hAA}}) begin
      miscompares++;
      $display("FAIL chk_good: ov=%0d w=%h want 1 aa..",
               ov_cnt - c0, w_out);
    end
    c0 = ov_cnt;
    send_bad(8'h02, {8{8'hAA}}, 8'h03);
    send_bad(8'h02, {8{8'h11}}, 8'h13);
    vectors++;
    if (ov_cnt != c0 || w_out !== {8{8'hAA}} ||
        x_out !== {64{1'b1}}) begin
      miscompares++;
      $display("FAIL chk_bad: ov=%0d w=%h x=%h want 0 aa.. ff..",
               ov_cnt - c0, w_out, x_out);
    end
    send_frame(8'h03, 64'h1234567890ABCDEF, 1'b0, 1'b0);
    drain();
    vectors++;
    if (w_out !== {8{8'hAA}} || x_out !== 64'h1234567890ABCDEF) begin
      miscompares++;
      $display("FAIL chk_after: w=%h x=%h want aa.. 1234567890abcdef",
               w_out, x_out);
    end
`endif
  endtask

  task automatic test_reset_mid();
    send_byte(8'h03);
    for (int i = 0; i < 4; i++) send_byte(8'hEE);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mw = '0; mx = '0; ow = '0; ox = '0;
    sb.delete();
    vectors++;
    if (w_out !== 64'h0 || x_out !== 64'h0 ||
        out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_rst: w=%h x=%h ov=%b rdy=%b want 0 0 0 1",
               w_out, x_out, out_valid, in_ready);
    end
    send_frame(8'h03, 64'hF0E1D2C3B4A59687, 1'b0, 1'b1);
    drain();
    vectors++;
    if (x_out !== 64'hF0E1D2C3B4A59687 || w_out !== 64'h0) begin
      miscompares++;
      $display("FAIL mid_next: w=%h x=%h want 0 f0e1d2c3b4a59687",
               w_out, x_out);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [63:0] w0;
    c0 = ov_cnt;
    w0 = mw;
    send_frame(8'h03, {8{8'h55}}, 1'b0, 1'b0);
    send_frame(8'h03, {8{8'hAA}}, 1'b0, 1'b0);
    drain();
    vectors++;
    if (ov_cnt != c0 + 2) begin
      miscompares++;
      $display("FAIL b2b_cnt: %0d pulses want 2", ov_cnt - c0);
    end
    vectors++;
    if (x_out !== {8{8'hAA}} || w_out !== w0) begin
      miscompares++;
      $display("FAIL b2b_out: w=%h x=%h want %h aa..",
               w_out, x_out, w0);
    end
  endtask

  task automatic test_n3();
    @(negedge clk);
    in8_data = 8'h03;
    in8_valid = 1'b1;
    vectors++;
    if (in8_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL n3_rdy: %b want 1", in8_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in8_data = 8'h5A;
    @(posedge clk);
`ifdef OPERAND_LOADER_CHECKSUM_EN
    @(negedge clk);
    in8_data = 8'h59;
    @(posedge clk);
`endif
    @(negedge clk);
    in8_valid = 1'b0;
    vectors++;
    if (out8_valid !== 1'b0 || in8_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL n3_k1: ov=%b rdy=%b want 0 0",
               out8_valid, in8_ready);
    end
    @(negedge clk);
    vectors++;
    if (out8_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL n3_k2: ov=%b want 0", out8_valid);
    end
    @(negedge clk);
    vectors++;
    if (out8_valid !== 1'b1 || x8 !== 8'h5A || w8 !== 8'h00) begin
      miscompares++;
      $display("FAIL n3_out: ov=%b x=%h w=%h want 1 5a 00",
               out8_valid, x8, w8);
    end
    @(negedge clk);
    vectors++;
    if (out8_valid !== 1'b0 || err8 !== 1'b0) begin
      miscompares++;
      $display("FAIL n3_post: ov=%b err=%b want 0 0",
               out8_valid, err8);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_data = 8'h00;
    in_valid = 1'b0;
    in8_data = 8'h00;
    in8_valid = 1'b0;
    mw = '0; mx = '0; ow = '0; ox = '0;
    test_reset();
    test_basic();
    test_checksum();
    test_gap();
    test_reset_mid();
    test_back_to_back();
    test_n3();
    vectors++;
    if (err_cnt != exp_err) begin
      miscompares++;
      $display("FAIL err_cnt: %0d pulses want %0d", err_cnt, exp_err);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
